lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: data_bits, 8, width of data and address words.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: enable  input  1  thread active; low = all registers hold.
REQ-005 SHALL have port: core_state  input  3  core FSM state; 3'b011 = REQUEST, 3'b110 = UPDATE.
REQ-006 SHALL have port: dec_mem_read_en  input  1  current instruction is a load.
REQ-007 SHALL have port: dec_mem_write_en  input  1  current instruction is a store.
REQ-008 SHALL have port: rs  input  data_bits  address operand from the register file.
REQ-009 SHALL have port: rt  input  data_bits  store data from the register file.
REQ-010 SHALL have port: mem_read_valid  output  1  read request to the data-memory controller.
REQ-011 SHALL have port: mem_read_address  output  data_bits  read address.
REQ-012 SHALL have port: mem_read_ready  input  1  read complete; mem_read_data valid this cycle.
REQ-013 SHALL have port: mem_read_data  input  data_bits  returned read data.
REQ-014 SHALL have port: mem_write_valid  output  1  write request to the data-memory controller.
REQ-015 SHALL have port: mem_write_address  output  data_bits  write address.
REQ-016 SHALL have port: mem_write_data  output  data_bits  write data.
REQ-017 SHALL have port: mem_write_ready  input  1  write accepted.
REQ-018 SHALL have port: lsu_state  output  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11; the core stalls until every active thread reads DONE.
REQ-019 SHALL have port: lsu_out  output  data_bits  load result, consumed by the register file MEMORY write path.

Function
REQ-020 All outputs SHALL be registered; with enable low, every register holds its value.
REQ-021 IDLE: on core_state==REQUEST with dec_mem_read_en=1, SHALL go to REQUESTING as a read; with only dec_mem_write_en=1, as a write; with neither, stay IDLE.
REQ-022 When read_en and write_en are both 1, the read SHALL win and the write SHALL be dropped.
REQ-023 REQUESTING (read): SHALL set mem_read_valid=1 and mem_read_address=rs, then go to WAITING.
REQ-024 REQUESTING (write): SHALL set mem_write_valid=1, mem_write_address=rs and mem_write_data=rt, then go to WAITING.
REQ-025 In WAITING, valid, address and data SHALL remain stable until the matching ready is sampled high.
REQ-026 Read in WAITING with mem_read_ready=1: SHALL set lsu_out=mem_read_data, clear mem_read_valid, and go to DONE in the same edge.
REQ-027 Write in WAITING with mem_write_ready=1: SHALL clear mem_write_valid and go to DONE; lsu_out SHALL be unchanged.
REQ-028 Ready arriving in the same cycle valid first appears SHALL be accepted (zero-wait memory).
REQ-029 A ready for the non-active direction, or a ready in any state other than WAITING, SHALL be ignored.
REQ-030 DONE SHALL hold until core_state==UPDATE, then return to IDLE; this gives lsu_out a stable value for the UPDATE write.
REQ-031 Minimum load latency: REQUEST at edge t; valid seen after edge t+1; ready at edge t+2 gives DONE and lsu_out after edge t+2.
REQ-032 lsu_out SHALL hold its last load value until the next load completes.
REQ-033 At most one transaction SHALL be outstanding; a REQUEST seen outside IDLE SHALL be ignored.

Reset
REQ-034 On reset, lsu_state SHALL be IDLE and every output SHALL be 0, regardless of enable.
REQ-035 Reset in REQUESTING or WAITING SHALL drop valid at that edge and abandon the transaction; a late ready SHALL then be ignored.

Verification
REQ-036 Load: rs=0x2A, REQUEST, read_en=1, ready after 3 wait cycles with data=0x5C -> mem_read_address=0x2A held for the whole wait; lsu_out=0x5C; DONE until UPDATE, then IDLE.
REQ-037 Store: rs=0x10, rt=0xEE, write_en=1, ready on the first valid cycle -> one-cycle write with address 0x10 and data 0xEE; lsu_out unchanged; DONE.
REQ-038 Both enables set: rs=0x03 -> read only, mem_write_valid never rises.
REQ-039 Stall: enable low for 4 cycles during WAITING with ready high -> no state change; on enable=1, the read completes.
REQ-040 Reset during WAITING, then ready pulses -> IDLE, all outputs 0, the ready is ignored, and the next load works normally.

Source files
------------

// File: rtl/lsu_if.sv
// Data-memory handshake bundle between the LSU (master) and the memory controller (slave).
// Read and write channels are independent valid/ready pairs.
interface lsu_if #(
  parameter int unsigned data_bits = 8
);
  logic                 mem_read_valid;
  logic [data_bits-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [data_bits-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [data_bits-1:0] mem_write_address;
  logic [data_bits-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one data-memory transaction per REQUEST and holds
// DONE until the core's UPDATE phase. All outputs are registered.
module lsu #(
  parameter int unsigned data_bits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 dec_mem_read_en,
  input  logic                 dec_mem_write_en,
  input  logic [data_bits-1:0] rs,
  input  logic [data_bits-1:0] rt,
  lsu_if.master                mem,
  output logic [1:0]           lsu_state,
  output logic [data_bits-1:0] lsu_out
);

  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreUpdate  = 3'b110;

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StRequesting = 2'b01,
    StWaiting    = 2'b10,
    StDone       = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 is_read_q, is_read_d;
  logic                 read_valid_q, read_valid_d;
  logic [data_bits-1:0] read_addr_q, read_addr_d;
  logic                 write_valid_q, write_valid_d;
  logic [data_bits-1:0] write_addr_q, write_addr_d;
  logic [data_bits-1:0] write_data_q, write_data_d;
  logic [data_bits-1:0] out_q, out_d;

  always_comb begin
    state_d       = state_q;
    is_read_d     = is_read_q;
    read_valid_d  = read_valid_q;
    read_addr_d   = read_addr_q;
    write_valid_d = write_valid_q;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    out_d         = out_q;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          // A load takes priority; a simultaneous store is dropped.
          if (core_state == CoreRequest && (dec_mem_read_en || dec_mem_write_en)) begin
            state_d   = StRequesting;
            is_read_d = dec_mem_read_en;
          end
        end
        StRequesting: begin
          if (is_read_q) begin
            read_valid_d = 1'b1;
            read_addr_d  = rs;
          end else begin
            write_valid_d = 1'b1;
            write_addr_d  = rs;
            write_data_d  = rt;
          end
          state_d = StWaiting;
        end
        StWaiting: begin
          if (is_read_q) begin
            if (mem.mem_read_ready) begin
              out_d        = mem.mem_read_data;
              read_valid_d = 1'b0;
              state_d      = StDone;
            end
          end else if (mem.mem_write_ready) begin
            write_valid_d = 1'b0;
            state_d       = StDone;
          end
        end
        StDone: begin
          if (core_state == CoreUpdate) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      is_read_q     <= 1'b0;
      read_valid_q  <= 1'b0;
      read_addr_q   <= '0;
      write_valid_q <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      is_read_q     <= is_read_d;
      read_valid_q  <= read_valid_d;
      read_addr_q   <= read_addr_d;
      write_valid_q <= write_valid_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      out_q         <= out_d;
    end
  end

  assign mem.mem_read_valid    = read_valid_q;
  assign mem.mem_read_address  = read_addr_q;
  assign mem.mem_write_valid   = write_valid_q;
  assign mem.mem_write_address = write_addr_q;
  assign mem.mem_write_data    = write_data_q;
  assign lsu_state             = state_q;
  assign lsu_out               = out_q;

endmodule
